// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the execute stage: opcodes, funct codes, ALU class
// and forwarding-select encodings, and the internal ALU operation set.
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // ALU class from the decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_IMM  = 2'b11;

    // B-operand select: only 01 picks the immediate
    localparam logic [1:0] ALUSRC_IMM = 2'b01;

    // Forwarding selects; 11 falls back to the ID/EX value
    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Link register written by JAL
    localparam logic [4:0] REG_RA = 5'd31;

    // Internal ALU operation set
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI,
        ALU_ZERO
    } alu_op_e;

endpackage

// File: rtl/ex_alu.sv
// Purely combinational ALU: operands A/B, shift amount and decoded operation
// in, result out. Arithmetic wraps; there is no overflow trap.
module ex_alu
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [4:0]         i_shamt,
    input  alu_op_e            i_op,
    output logic [NB_DATA-1:0] o_result
);

    // Evaluate the selected operation; shifts always act on B
    always_comb begin
        // NOTE: assign a default first so every path drives the output and no latch is inferred.
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLT:  o_result = {{(NB_DATA-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(NB_DATA-1){1'b0}}, (i_a < i_b)};
            ALU_SLL:  o_result = i_b << i_shamt;
            ALU_SRL:  o_result = i_b >> i_shamt;
            ALU_SRA:  o_result = NB_DATA'($signed(i_b) >>> i_shamt);
            ALU_LUI:  o_result = NB_DATA'(i_b[15:0]) << 16;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: operand forwarding, ALU op decode, ALU, and the EX/MEM
// register bank with halt-hold, $0 write suppression and a sticky stop flag.
module execute_stage
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_reg_DA,
    input  logic [NB_DATA-1:0] i_reg_DB,
    input  logic [NB_DATA-1:0] i_immediate,
    input  logic [5:0]         i_opcode,
    input  logic [5:0]         i_func,
    input  logic [4:0]         i_shamt,
    input  logic [NB_ADDR-1:0] i_rt,
    input  logic [NB_ADDR-1:0] i_rd,
    input  logic               i_regDst,
    input  logic               i_mem2Reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_sign_flag,
    input  logic               i_regWrite,
    input  logic [1:0]         i_aluSrc,
    input  logic [1:0]         i_aluOp,
    input  logic [1:0]         i_width,
    input  logic [1:0]         i_fwd_a,
    input  logic [1:0]         i_fwd_b,
    input  logic [NB_DATA-1:0] i_ex_mem_data,
    input  logic [NB_DATA-1:0] i_mem_wb_data,
    input  logic               i_stop,
    input  logic               i_halt,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_DATA-1:0] o_store_data,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic               o_regWrite,
    output logic               o_mem2Reg,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_sign_flag,
    output logic [1:0]         o_width,
    output logic               o_stop
);

    logic               is_link;
    logic [NB_DATA-1:0] fwd_a;
    logic [NB_DATA-1:0] fwd_b;
    logic [NB_DATA-1:0] op_b;
    logic [4:0]         alu_shamt;
    alu_op_e            alu_op;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_ADDR-1:0] wr_addr;

    // Forwarding muxes; JAL/JALR carry PC+4 and 4 in DA/DB, so forwarding is
    // bypassed to avoid a false match on rt=31
    always_comb begin
        is_link = (i_opcode == OP_JAL) || ((i_opcode == OP_RTYPE) && (i_func == FN_JALR));
        case (i_fwd_a)
            FWD_MEMWB: fwd_a = i_mem_wb_data;
            FWD_EXMEM: fwd_a = i_ex_mem_data;
            default:   fwd_a = i_reg_DA;
        endcase
        case (i_fwd_b)
            FWD_MEMWB: fwd_b = i_mem_wb_data;
            FWD_EXMEM: fwd_b = i_ex_mem_data;
            default:   fwd_b = i_reg_DB;
        endcase
        if (is_link) begin
            fwd_a = i_reg_DA;
            fwd_b = i_reg_DB;
        end
        op_b = (i_aluSrc == ALUSRC_IMM) ? i_immediate : fwd_b;
    end

    // Translate ALU class plus func/opcode into an internal ALU operation
    always_comb begin
        alu_op    = ALU_ZERO;
        alu_shamt = i_shamt;
        case (i_aluOp)
            ALUOP_ADD: alu_op = ALU_ADD;
            ALUOP_SUB: alu_op = ALU_SUB;
            ALUOP_FUNC: begin
                case (i_func)
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; alu_shamt = fwd_a[4:0]; end
                    FN_SRLV: begin alu_op = ALU_SRL; alu_shamt = fwd_a[4:0]; end
                    FN_SRAV: begin alu_op = ALU_SRA; alu_shamt = fwd_a[4:0]; end
                    FN_JALR, FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    default: alu_op = ALU_ZERO;
                endcase
            end
            ALUOP_IMM: begin
                case (i_opcode)
                    OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI:  alu_op = ALU_AND;
                    OP_ORI:   alu_op = ALU_OR;
                    OP_XORI:  alu_op = ALU_XOR;
                    OP_LUI:   alu_op = ALU_LUI;
                    default:  alu_op = ALU_ZERO;
                endcase
            end
            default: alu_op = ALU_ZERO;
        endcase
    end

    ex_alu #(
        .NB_DATA (NB_DATA)
    ) u_alu (
        .i_a      (fwd_a),
        .i_b      (op_b),
        .i_shamt  (alu_shamt),
        .i_op     (alu_op),
        .o_result (alu_result)
    );

    assign wr_addr = i_regDst ? i_rd : i_rt;

    // EX/MEM register bank: reset clears, halt holds, otherwise capture
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_result <= '0;
            o_store_data <= '0;
            o_wr_addr    <= '0;
            o_regWrite   <= 1'b0;
            o_mem2Reg    <= 1'b0;
            o_memRead    <= 1'b0;
            o_memWrite   <= 1'b0;
            o_sign_flag  <= 1'b0;
            o_width      <= '0;
            o_stop       <= 1'b0;
        end else if (!i_halt) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            o_alu_result <= alu_result;
            o_store_data <= fwd_b;
            o_wr_addr    <= wr_addr;
            o_regWrite   <= i_regWrite && (wr_addr != '0);
            o_mem2Reg    <= i_mem2Reg;
            o_memRead    <= i_memRead;
            o_memWrite   <= i_memWrite;
            o_sign_flag  <= i_sign_flag;
            o_width      <= i_width;
            o_stop       <= o_stop | i_stop;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver pushes hand-computed
// expectations as it issues each vector; a monitor pops and compares one
// cycle later.
module tb_execute_stage;
    import mips_pkg::*;

    logic        clk;
    logic        i_rst_n;
    logic [31:0] i_reg_DA, i_reg_DB, i_immediate, i_ex_mem_data, i_mem_wb_data;
    logic [5:0]  i_opcode, i_func;
    logic [4:0]  i_shamt, i_rt, i_rd;
    logic        i_regDst, i_mem2Reg, i_memRead, i_memWrite, i_sign_flag, i_regWrite;
    logic [1:0]  i_aluSrc, i_aluOp, i_width, i_fwd_a, i_fwd_b;
    logic        i_stop, i_halt;
    logic [31:0] o_alu_result, o_store_data;
    logic [4:0]  o_wr_addr;
    logic        o_regWrite, o_mem2Reg, o_memRead, o_memWrite, o_sign_flag, o_stop;
    logic [1:0]  o_width;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  wa;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        sf;
        logic [1:0]  w;
        logic        st;
    } out_t;

    typedef struct {
        out_t  o;
        bit    care_res;
        string name;
    } exp_t;

    out_t act;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign act = {o_alu_result, o_store_data, o_wr_addr, o_regWrite, o_mem2Reg,
                  o_memRead, o_memWrite, o_sign_flag, o_width, o_stop};

    execute_stage #(.NB_DATA(32), .NB_ADDR(5)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_reg_DA(i_reg_DA), .i_reg_DB(i_reg_DB), .i_immediate(i_immediate),
        .i_opcode(i_opcode), .i_func(i_func), .i_shamt(i_shamt),
        .i_rt(i_rt), .i_rd(i_rd),
        .i_regDst(i_regDst), .i_mem2Reg(i_mem2Reg), .i_memRead(i_memRead),
        .i_memWrite(i_memWrite), .i_sign_flag(i_sign_flag), .i_regWrite(i_regWrite),
        .i_aluSrc(i_aluSrc), .i_aluOp(i_aluOp), .i_width(i_width),
        .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
        .i_ex_mem_data(i_ex_mem_data), .i_mem_wb_data(i_mem_wb_data),
        .i_stop(i_stop), .i_halt(i_halt),
        .o_alu_result(o_alu_result), .o_store_data(o_store_data), .o_wr_addr(o_wr_addr),
        .o_regWrite(o_regWrite), .o_mem2Reg(o_mem2Reg), .o_memRead(o_memRead),
        .o_memWrite(o_memWrite), .o_sign_flag(o_sign_flag), .o_width(o_width),
        .o_stop(o_stop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input out_t got, input out_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got res=%h sd=%h wa=%0d rw=%b m2r=%b mr=%b mw=%b sf=%b w=%b st=%b | required res=%h sd=%h wa=%0d rw=%b m2r=%b mr=%b mw=%b sf=%b w=%b st=%b",
                     name, got.res, got.sd, got.wa, got.rw, got.m2r, got.mr, got.mw, got.sf, got.w, got.st,
                     want.res, want.sd, want.wa, want.rw, want.m2r, want.mr, want.mw, want.sf, want.w, want.st);
        end
    endtask

    function automatic out_t mk(input logic [31:0] res, input logic [31:0] sd,
                                input logic [4:0] wa, input logic rw,
                                input logic m2r = 1'b0, input logic mr = 1'b0,
                                input logic mw = 1'b0, input logic sf = 1'b0,
                                input logic [1:0] w = 2'b00, input logic st = 1'b0);
        out_t o;
        o = {res, sd, wa, rw, m2r, mr, mw, sf, w, st};
        return o;
    endfunction

    task automatic push(input string name, input out_t o, input bit care_res = 1'b1);
        exp_t e;
        e.o = o;
        e.care_res = care_res;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // All-zero ID/EX bundle: a bubble
    task automatic idle();
        i_reg_DA = '0; i_reg_DB = '0; i_immediate = '0;
        i_ex_mem_data = '0; i_mem_wb_data = '0;
        i_opcode = '0; i_func = '0; i_shamt = '0; i_rt = '0; i_rd = '0;
        i_regDst = 0; i_mem2Reg = 0; i_memRead = 0; i_memWrite = 0;
        i_sign_flag = 0; i_regWrite = 0;
        i_aluSrc = '0; i_aluOp = '0; i_width = '0; i_fwd_a = '0; i_fwd_b = '0;
        i_stop = 0; i_halt = 0;
    endtask

    // Start a new vector on the falling edge with a clean bundle
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [31:0] da, input logic [31:0] db,
                         input logic [4:0] rd);
        i_opcode = OP_RTYPE; i_func = fn; i_aluOp = ALUOP_FUNC;
        i_reg_DA = da; i_reg_DB = db; i_rd = rd; i_regDst = 1; i_regWrite = 1;
    endtask

    // Monitor: every cycle that had a vector issued, compare one edge later
    initial begin
        forever begin
            int   pend;
            exp_t e;
            out_t a;
            @(posedge clk);
            pend = exp_q.size();
            #1;
            if (pend > 0) begin
                e = exp_q.pop_front();
                a = act;
                if (!e.care_res) begin
                    a.res = '0;
                    e.o.res = '0;
                end
                check(e.name, a, e.o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 check("reset_state", act, '0);
        @(negedge clk) i_rst_n = 1'b1;

        step(); rtype(FN_ADDU, 32'd5, 32'd7, 5'd3);
        push("addu", mk(32'd12, 32'd7, 5'd3, 1));

        step(); rtype(FN_SUBU, 32'd0, 32'd1, 5'd4);
        i_fwd_a = FWD_EXMEM; i_ex_mem_data = 32'd100;
        push("subu_fwd_exmem", mk(32'd99, 32'd1, 5'd4, 1));

        step(); rtype(FN_SUBU, 32'd0, 32'd1, 5'd4);
        i_fwd_a = FWD_EXMEM; i_ex_mem_data = 32'd100;
        i_fwd_b = FWD_MEMWB; i_mem_wb_data = 32'd9;
        push("subu_fwd_memwb", mk(32'd91, 32'd9, 5'd4, 1));

        step(); rtype(FN_ADDU, 32'd2, 32'd3, 5'd5);
        i_fwd_a = 2'b11; i_fwd_b = 2'b11; i_ex_mem_data = 32'd100; i_mem_wb_data = 32'd9;
        push("fwd_11_is_idex", mk(32'd5, 32'd3, 5'd5, 1));

        step(); rtype(FN_SRA, 32'd0, 32'h8000_0000, 5'd6); i_shamt = 5'd4;
        push("sra", mk(32'hF800_0000, 32'h8000_0000, 5'd6, 1));

        step(); rtype(FN_SRAV, 32'd8, 32'h8000_0000, 5'd7);
        push("srav", mk(32'hFF80_0000, 32'h8000_0000, 5'd7, 1));

        step(); rtype(FN_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd8);
        push("sltu", mk(32'd0, 32'd1, 5'd8, 1));

        step(); rtype(FN_SLT, 32'hFFFF_FFFF, 32'd1, 5'd8);
        push("slt", mk(32'd1, 32'd1, 5'd8, 1));

        step(); i_opcode = OP_LUI; i_aluOp = ALUOP_IMM; i_aluSrc = ALUSRC_IMM;
        i_immediate = 32'h0000_1234; i_rt = 5'd9; i_regWrite = 1;
        push("lui", mk(32'h1234_0000, 32'd0, 5'd9, 1));

        step(); i_opcode = OP_JAL; i_aluOp = ALUOP_ADD;
        i_reg_DA = 32'h40; i_reg_DB = 32'd4; i_rt = 5'd31; i_regWrite = 1;
        i_fwd_b = FWD_EXMEM; i_ex_mem_data = 32'hDEAD;
        push("jal", mk(32'h44, 32'd4, REG_RA, 1));

        step(); i_opcode = 6'b101011; i_aluOp = ALUOP_ADD; i_aluSrc = ALUSRC_IMM;
        i_immediate = 32'd8; i_reg_DA = 32'h100; i_reg_DB = 32'hAB; i_rt = 5'd5;
        i_memWrite = 1; i_width = 2'b11;
        push("sw", mk(32'h108, 32'hAB, 5'd5, 0, 0, 0, 1, 0, 2'b11, 0));

        step(); i_opcode = 6'b100011; i_aluOp = ALUOP_ADD; i_aluSrc = ALUSRC_IMM;
        i_immediate = 32'd4; i_reg_DA = 32'h200; i_rt = 5'd10;
        i_memRead = 1; i_mem2Reg = 1; i_sign_flag = 1; i_regWrite = 1; i_width = 2'b01;
        push("lw", mk(32'h204, 32'd0, 5'd10, 1, 1, 1, 0, 1, 2'b01, 0));

        step(); i_opcode = OP_ADDI; i_aluOp = ALUOP_IMM; i_aluSrc = ALUSRC_IMM;
        i_immediate = 32'd5; i_reg_DA = 32'd1; i_rt = 5'd0; i_regWrite = 1;
        push("addi_to_r0", mk(32'd6, 32'd0, 5'd0, 0));

        step(); rtype(6'b111111, 32'd1, 32'd2, 5'd3);
        push("unknown_func", mk(32'd0, 32'd2, 5'd3, 1));

        step(); rtype(FN_NOR, 32'h0F0F_0000, 32'h0000_00FF, 5'd11);
        push("nor", mk(32'hF0F0_FF00, 32'h0000_00FF, 5'd11, 1));

        step(); rtype(FN_JALR, 32'h80, 32'd4, 5'd31);
        i_fwd_a = FWD_EXMEM; i_ex_mem_data = 32'h999;
        i_fwd_b = FWD_MEMWB; i_mem_wb_data = 32'h777;
        push("jalr", mk(32'h84, 32'd4, 5'd31, 1));

        step();
        push("bubble", mk(32'd0, 32'd0, 5'd0, 0), 1'b0);

        // Capture one value, then freeze for three cycles with changing inputs
        step(); rtype(FN_ADDU, 32'd1, 32'd1, 5'd2);
        push("pre_halt", mk(32'd2, 32'd1, 5'd2, 1));
        for (int i = 0; i < 3; i++) begin
            step(); rtype(FN_SUBU, 32'd50 + i, 32'd3, 5'(12 + i));
            i_memWrite = 1; i_width = 2'b10; i_halt = 1; i_stop = (i == 1);
            push("halt_hold", mk(32'd2, 32'd1, 5'd2, 1));
        end

        step(); i_stop = 1;
        push("stop_set", mk(32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0, 2'b00, 1), 1'b0);
        step();
        push("stop_sticky", mk(32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0, 2'b00, 1), 1'b0);
        step(); rtype(FN_ADDU, 32'd3, 32'd4, 5'd1);
        push("stop_sticky_op", mk(32'd7, 32'd4, 5'd1, 1, 0, 0, 0, 0, 2'b00, 1));

        // Asynchronous reset between edges
        @(posedge clk);
        #3 i_rst_n = 1'b0;
        #1 check("async_reset", act, '0);
        step(); i_rst_n = 1'b0; rtype(FN_ADDU, 32'd9, 32'd9, 5'd9); i_stop = 1;
        @(posedge clk);
        #1 check("reset_held", act, '0);
        step(); i_rst_n = 1'b1; rtype(FN_ADDU, 32'd10, 32'd20, 5'd2);
        push("post_reset", mk(32'd30, 32'd20, 5'd2, 1));
        step();

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
